// File: rtl/ga_pkg.sv
// Shared GA types and default sizes.
// Imported by the fitness, selection and elitism stages.
package ga_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    RUN   = 2'd1,
    DONE  = 2'd2
  } elite_state_t;

  localparam int GA_POP_SIZE = 16;
  localparam int GA_CHROM_W  = 32;
  localparam int GA_FIT_W    = 27;

endpackage

// File: rtl/pair_max.sv
// Signed max of a chromosome pair; ties pick chrom1.
// In: chrom1_i/chrom2_i, fit1_i/fit2_i. Out: win_chrom_o, win_fit_o.
module pair_max
  import ga_pkg::*;
#(
  parameter int CHROM_W = GA_CHROM_W,
  parameter int FIT_W   = GA_FIT_W
) (
  input  logic        [CHROM_W-1:0] chrom1_i,
  input  logic        [CHROM_W-1:0] chrom2_i,
  input  logic signed [FIT_W-1:0]   fit1_i,
  input  logic signed [FIT_W-1:0]   fit2_i,
  output logic        [CHROM_W-1:0] win_chrom_o,
  output logic signed [FIT_W-1:0]   win_fit_o
);

  logic pick2;

  assign pick2       = fit2_i > fit1_i;
  assign win_chrom_o = pick2 ? chrom2_i : chrom1_i;
  assign win_fit_o   = pick2 ? fit2_i : fit1_i;

endmodule

// File: rtl/elite_tracker.sv
// Elitism record, generation/stall counting and run-finished flag.
// In: clk, reset(n), clear, in_valid, chrom/fit pair. Out: best*, counts, gen_end, done.
module elite_tracker
  import ga_pkg::*;
#(
  parameter int POP_SIZE    = GA_POP_SIZE,
  parameter int CHROM_W     = GA_CHROM_W,
  parameter int FIT_W       = GA_FIT_W,
  parameter int MAX_GEN     = 64,
  parameter int STALL_LIMIT = 8
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   clear,
  input  logic                                   in_valid,
  input  logic        [CHROM_W-1:0]              chrom1,
  input  logic        [CHROM_W-1:0]              chrom2,
  input  logic signed [FIT_W-1:0]                fit1,
  input  logic signed [FIT_W-1:0]                fit2,
  output logic        [CHROM_W-1:0]              best,
  output logic signed [FIT_W-1:0]                best_fit,
  output logic                                   best_valid,
  output logic [$clog2(MAX_GEN+1)-1:0]           gen_count,
  output logic [$clog2(STALL_LIMIT+1)-1:0]       stall_count,
  output logic                                   gen_end,
  output logic                                   done
);

  localparam int NP = POP_SIZE / 2;
  localparam int PW = (NP > 1) ? $clog2(NP) : 1;
  localparam int GW = $clog2(MAX_GEN + 1);
  localparam int SW = $clog2(STALL_LIMIT + 1);
  localparam logic [PW-1:0] PLAST = PW'(NP - 1);
  localparam logic [GW-1:0] GMAX  = GW'(MAX_GEN);
  localparam logic [SW-1:0] SMAX  = SW'(STALL_LIMIT);

  elite_state_t state_q, state_d;

  logic        [CHROM_W-1:0] best_q, best_d;
  logic signed [FIT_W-1:0]   fit_q, fit_d;
  logic                      bv_q, bv_d;
  logic        [GW-1:0]      gen_q, gen_d;
  logic        [SW-1:0]      stall_q, stall_d;
  logic                      ge_q, ge_d;
  logic        [PW-1:0]      pair_q, pair_d;
  logic                      imp_q, imp_d;

  logic        [CHROM_W-1:0] win_chrom;
  logic signed [FIT_W-1:0]   win_fit;
  logic                      accept;
  logic                      better;
  logic                      last;
  logic        [GW-1:0]      gen_inc;
  logic        [SW-1:0]      stall_nxt;

  pair_max #(
    .CHROM_W (CHROM_W),
    .FIT_W   (FIT_W)
  ) u_pair_max (
    .chrom1_i    (chrom1),
    .chrom2_i    (chrom2),
    .fit1_i      (fit1),
    .fit2_i      (fit2),
    .win_chrom_o (win_chrom),
    .win_fit_o   (win_fit)
  );

  assign accept  = in_valid && (state_q != DONE);
  assign better  = (state_q == EMPTY) || (win_fit > fit_q);
  assign last    = pair_q == PLAST;
  assign gen_inc = gen_q + 1'b1;

  // An improvement anywhere in the generation, including its last pair,
  // resets the stall run.
  always_comb begin
    stall_nxt = stall_q;
    if (imp_q || better)
      stall_nxt = '0;
    else if (stall_q != SMAX)
      stall_nxt = stall_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear)
      state_d = EMPTY;
    else if (accept) begin
      if (last && (gen_inc == GMAX || stall_nxt == SMAX))
        state_d = DONE;
      else
        state_d = RUN;
    end
  end

  always_comb begin
    best_d  = best_q;
    fit_d   = fit_q;
    bv_d    = bv_q;
    gen_d   = gen_q;
    stall_d = stall_q;
    ge_d    = 1'b0;
    pair_d  = pair_q;
    imp_d   = imp_q;
    if (clear) begin
      best_d  = '0;
      fit_d   = '0;
      bv_d    = 1'b0;
      gen_d   = '0;
      stall_d = '0;
      pair_d  = '0;
      imp_d   = 1'b0;
    end else if (accept) begin
      if (better) begin
        best_d = win_chrom;
        fit_d  = win_fit;
        bv_d   = 1'b1;
      end
      if (last) begin
        pair_d  = '0;
        imp_d   = 1'b0;
        ge_d    = 1'b1;
        gen_d   = gen_inc;
        stall_d = stall_nxt;
      end else begin
        pair_d = pair_q + 1'b1;
        imp_d  = imp_q || better;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      best_q  <= '0;
      fit_q   <= '0;
      bv_q    <= 1'b0;
      gen_q   <= '0;
      stall_q <= '0;
      ge_q    <= 1'b0;
      pair_q  <= '0;
      imp_q   <= 1'b0;
    end else begin
      best_q  <= best_d;
      fit_q   <= fit_d;
      bv_q    <= bv_d;
      gen_q   <= gen_d;
      stall_q <= stall_d;
      ge_q    <= ge_d;
      pair_q  <= pair_d;
      imp_q   <= imp_d;
    end
  end

  always_comb begin
    best        = best_q;
    best_fit    = fit_q;
    best_valid  = bv_q;
    gen_count   = gen_q;
    stall_count = stall_q;
    gen_end     = ge_q;
    done        = state_q == DONE;
  end

endmodule

// File: doc/elite_tracker.md
Name: elite_tracker

Overview:
- Sits downstream of the fitness stage, in parallel with selection.
- Consumes each evaluated chromosome pair with its two fitness values and keeps the best chromosome seen so far (elitism record).
- Counts pairs into generations and tracks generations without improvement.
- Raises done when the generation limit or the stall limit is reached.
- Drives the top-level best/best_fit outputs and the GA FINISHED transition.

Parameters:
POP_SIZE, 16, chromosomes per generation; must be even and ≥4; POP_SIZE/2 pairs make one generation
CHROM_W, 32, chromosome width
FIT_W, 27, signed fitness width
MAX_GEN, 64, generation limit; done after this many complete generations
STALL_LIMIT, 8, consecutive non-improving generations that force done

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
clear  in  1  synchronous restart; same effect as reset, ignored while reset is asserted
in_valid  in  1  chrom/fit pair valid this cycle
chrom1  in  CHROM_W  first chromosome of pair
chrom2  in  CHROM_W  second chromosome of pair
fit1  in  FIT_W  signed fitness of chrom1
fit2  in  FIT_W  signed fitness of chrom2
best  out  CHROM_W  best chromosome so far
best_fit  out  FIT_W  signed fitness of best
best_valid  out  1  best/best_fit hold real data
gen_count  out  $clog2(MAX_GEN+1)  completed generations
stall_count  out  $clog2(STALL_LIMIT+1)  consecutive non-improving generations
gen_end  out  1  one-cycle pulse: a generation completed
done  out  1  level; run finished

Behaviour:
- Reset values (reset low, or clear high at an edge): best=0, best_fit=0, best_valid=0, gen_count=0, stall_count=0, gen_end=0, done=0, pair counter=0, improved flag=0, state=EMPTY.
- States:
  - EMPTY: no best recorded. First accepted pair loads best → RUN.
  - RUN: normal tracking.
  - DONE: done=1; in_valid ignored; all outputs held until reset/clear.
- Pair accept: in_valid=1 and state≠DONE.
- Pair winner (combinational): fit2 > fit1 (signed) → chrom2/fit2, else chrom1/fit1. Ties go to chrom1.
- Update rule, latency 1 cycle (registered on the accept edge):
  - In EMPTY: the winner loads unconditionally; best_valid→1; improved flag set.
  - In RUN: load only if winner fitness > best_fit (strict signed). Ties keep the older best. A load sets the improved flag.
- Pair counter runs 0..POP_SIZE/2-1 and increments on each accept. An accept at POP_SIZE/2-1 wraps it to 0 and is the generation boundary.
- Generation boundary, on the same edge as the last pair's update:
  - gen_end=1 for exactly that cycle.
  - gen_count+1.
  - If the improved flag is set, or the last pair itself improves: stall_count→0. Otherwise stall_count+1, saturating at STALL_LIMIT.
  - The improved flag clears for the new generation.
  - If the new gen_count==MAX_GEN or the new stall_count==STALL_LIMIT → DONE, with done=1 on the same edge as gen_end.
- gen_count saturates at MAX_GEN; it cannot exceed it because DONE is entered first.
- in_valid low: no state change.
- Reset asserted mid-generation: asynchronous clear of everything, including a partial pair count.
- clear while DONE: returns to EMPTY on the next edge.

Decomposition:
- Shared package ga_pkg:
  - elite_state_t enum (EMPTY, RUN, DONE).
  - POP_SIZE default (replaces the `define).
  - CHROM_W and FIT_W defaults.
- Sub-module pair_max: combinational signed compare of fit1/fit2 that outputs the winning chromosome and fitness. It is reusable by the selection stage.
- Counters and FSM stay in elite_tracker.

Test Plan:
- Reset sanity: hold reset low with in_valid toggling → all outputs 0 and best_valid=0. Release reset; first pair chrom1=0xA, fit1=5, chrom2=0xB, fit2=-3 → next cycle best=0xA, best_fit=5, best_valid=1.
- Tie handling: best_fit=5, then pair fit1=5, fit2=5 → best unchanged. Then pair fit2=6, chrom2=0xC → best=0xC, best_fit=6.
- Signed compare: all fitness negative, pair (-100, -2) → best_fit=-2. A later pair (-1, -50) → best_fit=-1.
- Generation/stall, POP_SIZE=16, STALL_LIMIT=8: feed 8 non-improving pairs per generation after generation 0.
  - gen_end pulses every 8 accepts.
  - stall_count steps 1..8.
  - done rises with the 9th gen_end (gen_count=9).
  - Later in_valid leaves every output unchanged.
- MAX_GEN, set to 4 with an improvement every generation: done=1 on the 4th gen_end with stall_count=0. Improvement on the last pair of a generation keeps stall_count=0.
- Mid-run reset and clear:
  - Assert reset low asynchronously (between edges) after 5 pairs → outputs clear immediately.
  - After reset, a full generation needs 8 fresh accepts.
  - clear pulse in DONE → state EMPTY and done=0 next cycle.
